game_step_sequencer: RTL and testbench

//  Sequences every game step of the snake datapath (move/map update) in a two-board link game.
//  - Times the step period and latches the local player's direction.
//  - Exchanges the direction with the remote board over a byte-link handshake and waits for the remote direction.
//  - Fires the snake1/snake2 step strobes, then samples collision results and declares game over / winner.
//  - Sits between keyboard/link front-ends and the move datapath plus the collision checker.

---
 rtl/game_step_sequencer_if.sv | 28 ++
 rtl/game_step_sequencer.sv | 97 +++++++++
 tb/tb_game_step_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_step_sequencer_if.sv
// game_step_sequencer_if: keyboard, link and collision signals of the step sequencer
interface game_step_sequencer_if;
  logic       start;
  logic [2:0] key_dir;
  logic       tx_ready;
  logic       tx_valid;
  logic [2:0] tx_dir;
  logic       rx_valid;
  logic [2:0] rx_dir;
  logic       hit1;
  logic       hit2;
  logic       step1;
  logic       step2;
  logic [2:0] dir1;
  logic [2:0] dir2;
  logic       running;
  logic       game_over;
  logic [1:0] winner;
  logic       link_err;
  modport master (
    input  start, key_dir, tx_ready, rx_valid, rx_dir, hit1, hit2,
    output tx_valid, tx_dir, step1, step2, dir1, dir2, running, game_over, winner, link_err
  );
  modport slave (
    output start, key_dir, tx_ready, rx_valid, rx_dir, hit1, hit2,
    input  tx_valid, tx_dir, step1, step2, dir1, dir2, running, game_over, winner, link_err
  );
endinterface

// File: rtl/game_step_sequencer.sv
// game_step_sequencer: paced two-board snake step FSM (link exchange, step strobes, game over)
// Defining SEQ_PAUSE_EN adds a pause input that freezes the step timer in WAIT_TICK.
module game_step_sequencer #(
  parameter int TICK_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input logic clk,
  input logic rst,
`ifdef SEQ_PAUSE_EN
  input logic pause,
`endif
  game_step_sequencer_if.master bus
);
  localparam logic [2:0] NONE = 3'd0, UP = 3'd1, DOWN = 3'd2, LEFT = 3'd3, RIGHT = 3'd4;
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [3:0] {IDLE, WAIT_TICK, LATCH, SEND, WAIT_RX, APPLY, SETTLE, CHECK, OVER} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tick;
  logic [OW-1:0] tmo;
  logic [2:0] pend, rxb_dir, rx_dir_eff, dir1, dir2;
  logic [1:0] winner;
  logic rxb_v, rx_acc, tick_end, tmo_end, hold, go, hit_any, running, link_err;
  function automatic logic [2:0] rev(input logic [2:0] d);
    rev = d == UP ? DOWN : d == DOWN ? UP : d == LEFT ? RIGHT : d == RIGHT ? LEFT : NONE;
  endfunction
`ifdef SEQ_PAUSE_EN
  assign hold = pause && state == WAIT_TICK;
`else
  assign hold = 1'b0;
`endif
  assign running        = state != IDLE && state != OVER;
  assign bus.running    = running;
  assign bus.game_over  = state == OVER;
  assign bus.tx_valid   = state == SEND;
  assign bus.tx_dir     = dir1;
  assign bus.step1      = state == APPLY;
  assign bus.step2      = state == APPLY;
  assign bus.dir1       = dir1;
  assign bus.dir2       = dir2;
  assign bus.winner     = winner;
  assign bus.link_err   = link_err;
  always_comb begin
    go         = !running && bus.start;
    tick_end   = tick == TW'(TICK_CYCLES - 1);
    tmo_end    = tmo == OW'(TIMEOUT_CYCLES - 1);
    rx_acc     = state == WAIT_RX && (rxb_v || bus.rx_valid);
    rx_dir_eff = rxb_v ? rxb_dir : bus.rx_dir;
    hit_any    = bus.hit1 || bus.hit2;
    state_nx   = state;
    case (state)
      IDLE, OVER: state_nx = bus.start ? WAIT_TICK : state;
      WAIT_TICK:  state_nx = (tick_end && !hold) ? LATCH : WAIT_TICK;
      LATCH:      state_nx = SEND;
      SEND:       state_nx = bus.tx_ready ? WAIT_RX : SEND;
      WAIT_RX:    state_nx = rx_acc ? APPLY : tmo_end ? OVER : WAIT_RX;
      APPLY:      state_nx = SETTLE;
      SETTLE:     state_nx = CHECK;
      CHECK:      state_nx = hit_any ? OVER : WAIT_TICK;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick     <= '0;
      tmo      <= '0;
      pend     <= NONE;
      rxb_v    <= 1'b0;
      rxb_dir  <= NONE;
      dir1     <= UP;
      dir2     <= UP;
      winner   <= 2'b00;
      link_err <= 1'b0;
    end else begin
      state   <= state_nx;
      pend    <= (state == LATCH || bus.key_dir != NONE) ? bus.key_dir : pend;
      tmo     <= state != WAIT_RX ? '0 : tmo == OW'(TIMEOUT_CYCLES) ? tmo : tmo + OW'(1);
      // remote direction arriving before our own send completes waits for WAIT_RX
      rxb_v   <= state == SEND && (rxb_v || bus.rx_valid);
      rxb_dir <= (state == SEND && bus.rx_valid) ? bus.rx_dir : rxb_dir;
      if (go) begin
        tick     <= '0;
        dir1     <= UP;
        dir2     <= UP;
        winner   <= 2'b00;
        link_err <= 1'b0;
      end else begin
        if (running && !hold) tick <= tick_end ? '0 : tick + TW'(1);
        if (state == LATCH && pend != NONE && pend != rev(dir1)) dir1 <= pend;
        if (rx_acc && rx_dir_eff != NONE) dir2 <= rx_dir_eff;
        if (state == WAIT_RX && !rx_acc && tmo_end) link_err <= 1'b1;
        if (state == CHECK) winner <= {bus.hit1, bus.hit2};
      end
    end
  end
endmodule

// File: tb/tb_game_step_sequencer.sv
// tb_game_step_sequencer: directed + randomized steps against a step-level reference model
module tb_game_step_sequencer;
  localparam logic [2:0] NONE = 3'd0, UP = 3'd1, DOWN = 3'd2, LEFT = 3'd3, RIGHT = 3'd4;
  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef SEQ_PAUSE_EN
  logic pause = 1'b0;
`endif
  int passed = 0, failed = 0, total = 0, cyc_n = 0, last_send = 0;
  logic [2:0] d1m = UP, d2m = UP, pm = NONE;
  logic [2:0] opp [5] = '{NONE, DOWN, UP, RIGHT, LEFT};
  game_step_sequencer_if bus();
  game_step_sequencer #(.TICK_CYCLES(16), .TIMEOUT_CYCLES(40)) dut (
    .clk(clk),
    .rst(rst),
`ifdef SEQ_PAUSE_EN
    .pause(pause),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_running"}, bus.running, 0);
    check({tag, "_game_over"}, bus.game_over, 0);
    check({tag, "_tx_valid"}, bus.tx_valid, 0);
    check({tag, "_step"}, {bus.step1, bus.step2}, 0);
    check({tag, "_dir1"}, bus.dir1, UP);
    check({tag, "_dir2"}, bus.dir2, UP);
    check({tag, "_winner"}, bus.winner, 0);
    check({tag, "_link_err"}, bus.link_err, 0);
  endtask
  task automatic start_game();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    d1m = UP;
    d2m = UP;
    check("start_running", bus.running, 1);
    check("start_link_err", bus.link_err, 0);
    check("start_game_over", bus.game_over, 0);
  endtask
  // waits for SEND and checks the direction that LATCH committed
  task automatic reach_send(input bit first, input int extra);
    int n = 0;
    while (!bus.tx_valid && n < 40) begin
      cyc();
      n++;
    end
    check("send_seen", bus.tx_valid, 1);
    if (pm != NONE && pm != opp[d1m]) d1m = pm;
    pm = NONE;
    if (!first) check("period", cyc_n - last_send, 16 + extra);
    last_send = cyc_n;
    check("tx_dir", bus.tx_dir, d1m);
    check("dir1", bus.dir1, d1m);
  endtask
  task automatic press_keys(input logic [2:0] k0, input logic [2:0] k1, input bit do_start);
    bus.key_dir  = k0;
    bus.rx_valid = 1'b1;
    bus.rx_dir   = k1;
    bus.start    = do_start;
    if (k0 != NONE) pm = k0;
    cyc();
    bus.key_dir  = k1;
    bus.rx_valid = 1'b0;
    bus.start    = 1'b0;
    if (k1 != NONE) pm = k1;
    cyc();
    bus.key_dir = NONE;
  endtask
  task automatic run_step(input int w, input int r, input logic [2:0] k0, input logic [2:0] k1,
                          input logic [2:0] rd, input logic h1, input logic h2, input bit early,
                          input bit do_start, input int pz, input bit first);
    int extra = 0;
`ifdef SEQ_PAUSE_EN
    extra = pz;
    if (pz > 0) begin
      pause = 1'b1;
      repeat (pz) cyc();
      pause = 1'b0;
    end
`endif
    press_keys(k0, k1, do_start);
    reach_send(first, extra);
    for (int i = 0; i < w; i++) begin
      if (early && i == 0) begin
        bus.rx_valid = 1'b1;
        bus.rx_dir   = rd;
      end
      cyc();
      bus.rx_valid = 1'b0;
      check("hold_tx_valid", bus.tx_valid, 1);
      check("hold_tx_dir", bus.tx_dir, d1m);
      check("hold_no_step", bus.step1, 0);
    end
    bus.tx_ready = 1'b1;
    if (early && w == 0) begin
      bus.rx_valid = 1'b1;
      bus.rx_dir   = rd;
    end
    cyc();
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    check("rx_wait_tx_valid", bus.tx_valid, 0);
    if (!early) begin
      for (int i = 0; i < r; i++) begin
        check("rx_wait_no_step", {bus.step1, bus.step2}, 0);
        cyc();
      end
      bus.rx_valid = 1'b1;
      bus.rx_dir   = rd;
    end
    cyc();
    bus.rx_valid = 1'b0;
    if (rd != NONE) d2m = rd;
    check("step_pulse", {bus.step1, bus.step2}, 2'b11);
    check("dir2", bus.dir2, d2m);
    bus.hit1 = h1;
    bus.hit2 = h2;
    cyc();
    check("step_single", {bus.step1, bus.step2}, 0);
    repeat (2) cyc();
    bus.hit1 = 1'b0;
    bus.hit2 = 1'b0;
    check("game_over", bus.game_over, h1 | h2);
    check("running_after", bus.running, !(h1 | h2));
    if (h1 | h2) check("winner", bus.winner, h1 && h2 ? 2'b11 : h1 ? 2'b10 : 2'b01);
  endtask
  task automatic run_timeout();
    int n = 0;
    reach_send(0, 0);
    bus.tx_ready = 1'b1;
    cyc();
    bus.tx_ready = 1'b0;
    while (!bus.game_over && n < 100) begin
      cyc();
      n++;
    end
    check("timeout_cycles", n, 40);
    check("timeout_link_err", bus.link_err, 1);
    check("timeout_winner", bus.winner, 0);
    check("timeout_running", bus.running, 0);
  endtask
  task automatic run_reset(input bit in_send);
    reach_send(0, 0);
    if (!in_send) begin
      bus.tx_ready = 1'b1;
      cyc();
      bus.tx_ready = 1'b0;
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    d1m = UP;
    d2m = UP;
    pm  = NONE;
    check_idle(in_send ? "rst_send" : "rst_wait_rx");
  endtask
  initial begin
    bus.start = 1'b0; bus.key_dir = NONE; bus.tx_ready = 1'b0; bus.rx_valid = 1'b0;
    bus.rx_dir = NONE; bus.hit1 = 1'b0; bus.hit2 = 1'b0;
    repeat (3) cyc();
    check_idle("reset");
    rst = 1'b0;
    cyc();
    check("idle_no_start", bus.running, 0);
    start_game();
    run_step(0, 2, NONE, NONE, RIGHT, 0, 0, 0, 0, 0, 1);
    run_step(1, 1, DOWN, NONE, NONE, 0, 0, 0, 0, 0, 0);
    run_step(1, 1, DOWN, LEFT, UP, 0, 0, 0, 0, 0, 0);
    run_step(5, 0, NONE, NONE, LEFT, 0, 0, 0, 1, 0, 0);
    run_step(2, 0, UP, NONE, DOWN, 0, 0, 1, 0, 0, 0);
    run_step(0, 0, RIGHT, NONE, RIGHT, 0, 0, 1, 0, 20, 0);
    for (int s = 0; s < 10; s++)
      run_step($urandom_range(0, 3), $urandom_range(0, 3), 3'($urandom_range(0, 4)),
               3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), 0, 0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    run_step(1, 2, LEFT, NONE, UP, 1, 0, 0, 0, 0, 0);
    start_game();
    run_step(0, 1, NONE, DOWN, LEFT, 1, 1, 0, 0, 0, 1);
    start_game();
    run_step(2, 1, RIGHT, NONE, NONE, 0, 1, 0, 0, 0, 1);
    start_game();
    press_keys(LEFT, NONE, 0);
    reach_send(1, 0);
    bus.tx_ready = 1'b1;
    cyc();
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_dir   = DOWN;
    cyc();
    bus.rx_valid = 1'b0;
    d2m = DOWN;
    repeat (3) cyc();
    run_timeout();
    start_game();
    check("restart_dir1", bus.dir1, UP);
    run_step(1, 1, UP, NONE, LEFT, 0, 0, 0, 0, 0, 1);
    run_reset(0);
    start_game();
    run_step(0, 0, NONE, NONE, RIGHT, 0, 0, 0, 0, 0, 1);
    run_reset(1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
